// File: rtl/execute_memory_pipe_reg_if.sv
// Valid/ready bus carrying one EX->MEM instruction payload.
// master drives valid and payload, slave drives ready.
interface execute_memory_pipe_reg_if #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [DATA_W-1:0] alu;
  logic [DATA_W-1:0] mem;
  logic [REG_W-1:0]  rd;
  logic [CTRL_W-1:0] ctrl;

  modport master (output valid, output alu, output mem, output rd, output ctrl, input ready);
  modport slave  (input valid, input alu, input mem, input rd, input ctrl, output ready);
endinterface

// File: rtl/execute_memory_pipe_reg.sv
// EX->MEM pipeline register with valid/ready flow control, flush and a
// saturating stall-cycle counter.
// Build option EXMEM_SKID_EN: two-entry skid buffer with a registered
// in_ready; otherwise a single entry whose in_ready depends on out_ready.
module execute_memory_pipe_reg #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned CTRL_W = 8,
  parameter int unsigned CNT_W  = 16
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              flush,
  execute_memory_pipe_reg_if.slave          in_if,
  execute_memory_pipe_reg_if.master         out_if,
  output logic [CNT_W-1:0]                  stall_cnt
);

  typedef struct packed {
    logic [DATA_W-1:0] alu;
    logic [DATA_W-1:0] mem;
    logic [REG_W-1:0]  rd;
    logic [CTRL_W-1:0] ctrl;
  } entry_t;

  entry_t in_e;
  entry_t main_q, main_d;
  logic   in_ready;
  logic   out_valid;
  logic   in_xfer;
  logic   out_xfer;

  // Incoming payload packed into one entry
  always_comb begin
    in_e.alu  = in_if.alu;
    in_e.mem  = in_if.mem;
    in_e.rd   = in_if.rd;
    in_e.ctrl = in_if.ctrl;
  end

  assign in_xfer  = in_if.valid && in_ready;
  assign out_xfer = out_valid && out_if.ready;

`ifdef EXMEM_SKID_EN
  typedef enum logic [1:0] {EMPTY, BUSY, FULL} state_t;

  state_t state_q, state_d;
  entry_t skid_q, skid_d;
  logic   in_ready_q, in_ready_d;

  // Skid buffer next state; main always holds the oldest entry
  always_comb begin
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    case (state_q)
      EMPTY: begin
        if (in_xfer) begin
          state_d = BUSY;
          main_d  = in_e;
        end
      end
      BUSY: begin
        case ({in_xfer, out_xfer})
          2'b10: begin
            state_d = FULL;
            skid_d  = in_e;
          end
          2'b01: state_d = EMPTY;
          2'b11: main_d = in_e;
          default: ;
        endcase
      end
      FULL: begin
        if (out_xfer) begin
          state_d = BUSY;
          main_d  = skid_q;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
    // Invalid slots are zeroed so the bubble reads as a NOP
    if (state_d == EMPTY) main_d = '0;
    if (state_d != FULL)  skid_d = '0;
    in_ready_d = (state_d != FULL);
  end

  // Skid buffer state register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= EMPTY;
      main_q     <= '0;
      skid_q     <= '0;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      main_q     <= main_d;
      skid_q     <= skid_d;
      in_ready_q <= in_ready_d;
    end
  end

  assign out_valid = (state_q != EMPTY);
  assign in_ready  = rst_n && in_ready_q;
`else
  logic valid_q, valid_d;

  // Single entry: accept replaces a draining entry in the same cycle
  always_comb begin
    valid_d = valid_q;
    main_d  = main_q;
    if (out_xfer) valid_d = 1'b0;
    if (in_xfer) begin
      valid_d = 1'b1;
      main_d  = in_e;
    end
    if (flush) valid_d = 1'b0;
    if (!valid_d) main_d = '0;
  end

  // Single entry register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      main_q  <= '0;
    end else begin
      valid_q <= valid_d;
      main_q  <= main_d;
    end
  end

  assign out_valid = valid_q;
  assign in_ready  = rst_n && (!valid_q || out_if.ready);
`endif

  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  // Count cycles where Memory stalls a valid entry; stick at all-ones
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (out_valid && !out_if.ready && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
  end

  // Stall counter register; flush leaves it alone
  always_ff @(posedge clk) begin
    if (!rst_n) stall_cnt_q <= '0;
    else        stall_cnt_q <= stall_cnt_d;
  end

  assign in_if.ready = in_ready;
  assign out_if.valid = out_valid;
  assign out_if.alu   = main_q.alu;
  assign out_if.mem   = main_q.mem;
  assign out_if.rd    = main_q.rd;
  assign out_if.ctrl  = main_q.ctrl;
  assign stall_cnt    = stall_cnt_q;

endmodule

// File: tb/tb_execute_memory_pipe_reg.sv
// Bench for execute_memory_pipe_reg: directed scenarios followed by random
// valid/ready/flush traffic, checked every cycle against a queue model.
module tb_execute_memory_pipe_reg;
  localparam int unsigned DATA_W  = 16;
  localparam int unsigned REG_W   = 4;
  localparam int unsigned CTRL_W  = 8;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned E_W     = 2*DATA_W + REG_W + CTRL_W;
  localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst_n;
  logic             flush;
  logic [CNT_W-1:0] stall_cnt;

  execute_memory_pipe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) in_if ();
  execute_memory_pipe_reg_if #(.DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W)) out_if ();

  execute_memory_pipe_reg #(
    .DATA_W(DATA_W), .REG_W(REG_W), .CTRL_W(CTRL_W), .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .flush    (flush),
    .in_if    (in_if),
    .out_if   (out_if),
    .stall_cnt(stall_cnt)
  );

  // Reference: FIFO of accepted-but-not-drained entries, plus stall count
  logic [E_W-1:0] q[$];
  int unsigned    m_cnt = 0;
  int             n_cmp = 0;
  int             n_bad = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic model_in_ready();
    if (!rst_n) return 1'b0;
`ifdef EXMEM_SKID_EN
    return q.size() < 2;
`else
    return (q.size() == 0) || out_if.ready;
`endif
  endfunction

  task automatic check_out();
    logic [E_W-1:0] e;
    e = (q.size() > 0) ? q[0] : '0;
    chk("out_valid", 64'(out_if.valid), 64'(q.size() > 0));
    chk("out_alu",   64'(out_if.alu),   64'(e[E_W-1 -: DATA_W]));
    chk("out_mem",   64'(out_if.mem),   64'(e[E_W-DATA_W-1 -: DATA_W]));
    chk("out_rd",    64'(out_if.rd),    64'(e[CTRL_W+REG_W-1 -: REG_W]));
    chk("out_ctrl",  64'(out_if.ctrl),  64'(e[CTRL_W-1:0]));
    chk("stall_cnt", 64'(stall_cnt),    64'(m_cnt));
  endtask

  // One clock: check in_ready, advance model on the edge, check outputs after it
  task automatic cycle();
    logic           ir;
    logic           take;
    logic           give;
    logic           stalled;
    logic [E_W-1:0] din;
    #1;
    ir      = model_in_ready();
    chk("in_ready", 64'(in_if.ready), 64'(ir));
    take    = in_if.valid && ir;
    give    = (q.size() > 0) && out_if.ready;
    stalled = (q.size() > 0) && !out_if.ready;
    din     = {in_if.alu, in_if.mem, in_if.rd, in_if.ctrl};
    @(posedge clk);
    if (!rst_n) begin
      q.delete();
      m_cnt = 0;
    end else begin
      if (stalled && m_cnt < CNT_MAX) m_cnt++;
      if (give) void'(q.pop_front());
      if (take) q.push_back(din);
      if (flush) q.delete();
    end
    #1;
    check_out();
  endtask

  task automatic put(input logic v, input logic [DATA_W-1:0] alu);
    in_if.valid = v;
    in_if.alu   = alu;
    in_if.mem   = DATA_W'($urandom);
    in_if.rd    = REG_W'($urandom);
    in_if.ctrl  = CTRL_W'($urandom) | CTRL_W'(1);
  endtask

  initial begin
    rst_n        = 1'b0;
    flush        = 1'b0;
    out_if.ready = 1'b1;
    put(1'b0, '0);

    // Reset, then stream 1..5
    repeat (2) cycle();
    rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      put(1'b1, DATA_W'(i));
      cycle();
      chk("stream_alu", 64'(out_if.alu), 64'(i));
    end
    put(1'b0, '0);
    repeat (2) cycle();
    chk("stream_cnt", 64'(stall_cnt), 64'(0));

    // Backpressure with 0x00AA held at the output
    put(1'b1, DATA_W'(16'h00AA));
    cycle();
    chk("bp_head", 64'(out_if.alu), 64'h00AA);
    out_if.ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      put(1'b1, DATA_W'(16'h00B0 + k));
      cycle();
      chk("bp_hold", 64'(out_if.alu), 64'h00AA);
    end
    chk("bp_cnt", 64'(stall_cnt), 64'(3));
    put(1'b0, '0);
    out_if.ready = 1'b1;
    repeat (3) cycle();

    // Flush while holding an entry with a new input offered
    out_if.ready = 1'b0;
    put(1'b1, DATA_W'(16'h0011));
    cycle();
    put(1'b1, DATA_W'(16'h0F0F));
    flush = 1'b1;
    cycle();
    chk("flush_valid", 64'(out_if.valid), 64'(0));
    chk("flush_ctrl",  64'(out_if.ctrl),  64'(0));
    flush = 1'b0;
    put(1'b0, '0);
    out_if.ready = 1'b1;
    repeat (3) begin
      cycle();
      chk("flush_gone", 64'(out_if.valid), 64'(0));
    end

    // Counter saturation
    put(1'b1, DATA_W'(16'h0055));
    out_if.ready = 1'b0;
    cycle();
    put(1'b0, '0);
    repeat (20) cycle();
    chk("sat_cnt", 64'(stall_cnt), 64'(CNT_MAX));

    // Reset in the middle of a stall
    put(1'b1, DATA_W'(16'h0066));
    cycle();
    put(1'b0, '0);
    rst_n = 1'b0;
    cycle();
    chk("rst_valid", 64'(out_if.valid), 64'(0));
    chk("rst_cnt",   64'(stall_cnt),    64'(0));
    rst_n        = 1'b1;
    out_if.ready = 1'b1;
    #1;
    chk("rst_ready", 64'(in_if.ready), 64'(1));
    cycle();

    // Random traffic
    for (int n = 0; n < 10000; n++) begin
      put(1'($urandom_range(0, 1)), DATA_W'($urandom));
      out_if.ready = ($urandom_range(0, 3) != 0);
      flush        = ($urandom_range(0, 63) == 0);
      cycle();
    end
    flush = 1'b0;
    put(1'b0, '0);
    out_if.ready = 1'b1;
    repeat (3) cycle();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
